// File: rtl/pipe_skid_register.sv
// pipe_skid_register
//   Two-entry valid/ready pipeline register (main + skid slot). It sustains
//   one transfer per cycle, and in_ready is decoded from state flops only, so
//   there is no combinational path from out_ready to in_ready.
//
//   Parameters:
//     WIDTH       data width in bits (> 0)
//     RESET_DATA  value loaded into main and skid registers on reset
//
//   Ports:
//     clk, reset            rising-edge clock, async active-high reset
//     in_valid/in_ready     upstream handshake, in_data payload
//     flush                 synchronous discard of all held words
//     out_valid/out_ready   downstream handshake, out_data = main register
//     stall_cycles [15:0]   saturating count of cycles with out_valid & !out_ready
//                           (present only when PIPE_SKID_STALL_CNT_EN is defined)
//
//   Build option: define PIPE_SKID_STALL_CNT_EN to add the stall counter.

module pipe_skid_register #(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);

    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_skid_register: WIDTH must be > 0");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             in_fire, out_fire;

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_reg;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            main_reg <= RESET_DATA;
            skid_reg <= RESET_DATA;
        end else begin
            state    <= state_next;
            main_reg <= main_next;
            skid_reg <= skid_next;
        end
    end

    always_comb begin
        state_next = state;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            // Drop everything, including a word offered this cycle. The data
            // registers keep their contents; only the valid state is cleared.
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_next = in_data;
                    end else if (in_fire) begin
                        // Head is stalled; park the new word behind it.
                        state_next = TWO;
                        skid_next  = in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_next = ONE;
                        main_next  = skid_reg;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Cleared only by reset; flush leaves the history intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    // Stall counter not built.
`endif

endmodule

// File: tb/tb_pipe_skid_register.sv
// Testbench for pipe_skid_register: directed scenarios followed by random
// traffic, all compared against a two-deep FIFO reference model.
module tb_pipe_skid_register;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, flush, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]  stall_cycles;
    int           exp_stall;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: words held in arrival order, capacity two.
    logic [W-1:0] q[$];
    // Value shown on out_data when nothing is held: the last head word.
    logic [W-1:0] last_head;

    pipe_skid_register #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready",  W'(in_ready),  W'(q.size() < 2));
        chk("out_valid", W'(out_valid), W'(q.size() > 0));
        chk("out_data",  out_data, (q.size() > 0) ? q[0] : last_head);
`ifdef PIPE_SKID_STALL_CNT_EN
        chk("stall_cycles", W'(stall_cycles), W'(exp_stall));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        last_head = ONES;
`ifdef PIPE_SKID_STALL_CNT_EN
        exp_stall = 0;
`endif
    endtask

    // One clock cycle: drive, check outputs, advance, update model.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        bit ifire, ofire;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        check_outputs();
        ifire = iv && (q.size() < 2);
        ofire = ordy && (q.size() > 0);
`ifdef PIPE_SKID_STALL_CNT_EN
        if ((q.size() > 0) && !ordy && (exp_stall < 65535)) exp_stall++;
`endif
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(d);
        end
        if (q.size() > 0) last_head = q[0];
        #1;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        model_reset();

        // Reset state
        #12;
        chk("rst_in_ready",  W'(in_ready),  W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data",  out_data, ONES);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Streaming at full rate with 1-cycle latency
        step(1'b1, 64'h1, 1'b1, 1'b0);
        chk("stream_d1", out_data, 64'h1);
        step(1'b1, 64'h2, 1'b1, 1'b0);
        chk("stream_d2", out_data, 64'h2);
        step(1'b1, 64'h3, 1'b1, 1'b0);
        chk("stream_d3", out_data, 64'h3);
        chk("stream_rdy", W'(in_ready), W'(1));
        step(1'b0, 64'h0, 1'b1, 1'b0);

        // Fill both slots, then drain in order
        step(1'b1, 64'hA, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 1'b0);
        chk("two_rdy",  W'(in_ready), W'(0));
        chk("two_head", out_data, 64'hA);
        step(1'b1, 64'hE, 1'b0, 1'b0);   // refused: in_ready low
        chk("two_hold", out_data, 64'hA);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("drain_b",   out_data, 64'hB);
        chk("drain_rdy", W'(in_ready), W'(1));
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("drain_empty", W'(out_valid), W'(0));
        step(1'b0, 64'h0, 1'b1, 1'b0);   // out_ready with nothing held

        // Flush in TWO beats a concurrent out_fire and a new word
        step(1'b1, 64'hA, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 1'b0);
        step(1'b1, 64'hC, 1'b1, 1'b1);
        chk("flush_valid", W'(out_valid), W'(0));
        chk("flush_rdy",   W'(in_ready),  W'(1));
        chk("flush_keep",  out_data, 64'hA);
        step(1'b1, 64'hD, 1'b0, 1'b0);
        chk("post_flush", out_data, 64'hD);
        step(1'b0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle while in TWO
        step(1'b1, 64'h5, 1'b0, 1'b0);
        step(1'b1, 64'h6, 1'b0, 1'b0);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_in_ready",  W'(in_ready),  W'(1));
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_out_data",  out_data, ONES);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
        end
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);

`ifdef PIPE_SKID_STALL_CNT_EN
        // Stall counter: exact count, saturation, immunity to flush
        reset = 1'b1;
        #2;
        model_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 64'h77, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("stall_5", W'(stall_cycles), W'(5));
        for (int i = 0; i < 70000; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("stall_sat", W'(stall_cycles), W'(16'hFFFF));
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("stall_flush", W'(stall_cycles), W'(16'hFFFF));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_register.md
Name: pipe_skid_register

Overview:
- Two-entry valid/ready pipeline register (main + skid slot) for inter-stage transfers in the pipelined core.
- Upstream writes with in_valid/in_ready; downstream reads with out_valid/out_ready.
- Full throughput (1 transfer/cycle) with in_ready driven only from state flops, so the ready path is not combinational from out_ready.
- Reset loads a parameterised value so stages can power up with all-ones.

Parameters:
- WIDTH, 64, data width in bits; must be > 0 (elaboration-time assert).
- RESET_DATA, all ones ({WIDTH{1'b1}}), value loaded into main and skid data registers on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  upstream data.
- flush  input  1  synchronous discard of all held words.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  head word (main register).

Behaviour:
- Reset: asynchronous, active-high.
  - state=EMPTY; main=skid=RESET_DATA; out_valid=0; in_ready=1; out_data=RESET_DATA.
  - Reset mid-operation discards all held words immediately.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Outputs:
  - in_ready = (state != TWO); decoded from state flops only.
  - out_valid = (state != EMPTY).
  - out_data = main.
- States and transitions (evaluated each rising edge):
  - EMPTY:
    - in_fire -> ONE, main<=in_data.
    - Else stay.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire only -> TWO, skid<=in_data.
    - out_fire only -> EMPTY.
    - Neither -> hold.
  - TWO (in_ready=0, so no in_fire):
    - out_fire -> ONE, main<=skid.
    - Else hold.
- Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N. Minimum latency 1 cycle.
- Ordering: strict FIFO. The skid word is never presented before the main word.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change, except on flush or reset.
- in_valid without in_ready: no state change; upstream holds its data.
- Flush:
  - Synchronous, highest priority; overrides any in_fire/out_fire in the same cycle.
  - Next state = EMPTY.
  - A word offered in the flush cycle is dropped.
  - main/skid data registers retain their contents (not reloaded); out_valid=0.
- X-safety: a control input with no effect in the current state (e.g. out_ready in EMPTY) changes nothing.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [15:0] counting cycles where out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Reset to 0 by reset only; flush does not clear it.
  - Counter updates on the same edge as the state.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with WIDTH=64 -> out_valid=0, in_ready=1, out_data=64'hFFFF_FFFF_FFFF_FFFF. Assert reset async mid-cycle in state TWO -> outputs return to reset values before the next clk edge.
- Stream 0x1,0x2,0x3 with out_ready=1 every cycle -> out_data 0x1,0x2,0x3 on consecutive cycles after a 1-cycle latency; in_ready stays 1.
- Send 0xA then 0xB with out_ready=0 -> state TWO, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA consumed, then 0xB; in_ready=1 one edge after the first out_fire.
- In TWO (0xA, 0xB held), assert flush together with out_ready=1 and in_valid=1 carrying 0xC -> next cycle out_valid=0, in_ready=1, 0xA/0xB/0xC all lost. Then send 0xD -> out_data=0xD.
- Random in_valid/out_ready (10k cycles, scoreboard) -> zero drops, zero duplicates, order preserved, out_data stable while stalled.
- With PIPE_SKID_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cycles=5. Force 70000 stall cycles -> stall_cycles=16'hFFFF. Flush -> value unchanged.
